// File: rtl/quad_step_fsm.sv
// Quadrature Gray-code detent tracker: turns one full legal A/B cycle into a CW or CCW step.
// Also flags illegal two-bit jumps.
module quad_step_fsm (
    input  logic clk,
    input  logic reset,
    input  logic i_enc_a,
    input  logic i_enc_b,
    output logic o_step_cw_c,
    output logic o_step_ccw_c,
    output logic o_step_cw,
    output logic o_step_ccw,
    output logic o_err
);

    // Every state except SYNC implies the ab value last seen.
    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_REST = 3'd1,
        ST_CW1  = 3'd2,
        ST_CW2  = 3'd3,
        ST_CW3  = 3'd4,
        ST_CCW1 = 3'd5,
        ST_CCW2 = 3'd6,
        ST_CCW3 = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_err_c;
    logic [1:0] w_ab;
    logic       r_step_cw;
    logic       r_step_ccw;
    logic       r_err;

    assign w_ab = {i_enc_a, i_enc_b};

    always_comb begin
        w_next       = r_state;
        o_step_cw_c  = 1'b0;
        o_step_ccw_c = 1'b0;
        w_err_c      = 1'b0;
        case (r_state)
            ST_SYNC: if (w_ab == 2'b00) w_next = ST_REST;
            ST_REST: case (w_ab)
                2'b01:   w_next = ST_CW1;
                2'b10:   w_next = ST_CCW1;
                2'b11:   w_err_c = 1'b1;
                default: ;
            endcase
            ST_CW1: case (w_ab)
                2'b11:   w_next = ST_CW2;
                2'b00:   w_next = ST_REST;
                2'b10:   w_err_c = 1'b1;
                default: ;
            endcase
            ST_CW2: case (w_ab)
                2'b10:   w_next = ST_CW3;
                2'b01:   w_next = ST_CW1;
                2'b00:   w_err_c = 1'b1;
                default: ;
            endcase
            ST_CW3: case (w_ab)
                2'b00: begin
                    w_next      = ST_REST;
                    o_step_cw_c = 1'b1;
                end
                2'b11:   w_next = ST_CW2;
                2'b01:   w_err_c = 1'b1;
                default: ;
            endcase
            ST_CCW1: case (w_ab)
                2'b11:   w_next = ST_CCW2;
                2'b00:   w_next = ST_REST;
                2'b01:   w_err_c = 1'b1;
                default: ;
            endcase
            ST_CCW2: case (w_ab)
                2'b01:   w_next = ST_CCW3;
                2'b10:   w_next = ST_CCW1;
                2'b00:   w_err_c = 1'b1;
                default: ;
            endcase
            ST_CCW3: case (w_ab)
                2'b00: begin
                    w_next       = ST_REST;
                    o_step_ccw_c = 1'b1;
                end
                2'b11:   w_next = ST_CCW2;
                2'b10:   w_err_c = 1'b1;
                default: ;
            endcase
            default: w_next = ST_SYNC;
        endcase
        // An illegal jump abandons any partial detent and forces resync at 00.
        if (w_err_c) w_next = ST_SYNC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SYNC;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_step_cw  <= o_step_cw_c;
            r_step_ccw <= o_step_ccw_c;
            r_err      <= w_err_c;
        end
    end

    assign o_step_cw  = r_step_cw;
    assign o_step_ccw = r_step_ccw;
    assign o_err      = r_err;

endmodule

// File: rtl/encoder_counter.sv
// Rotary encoder channel: detent decoder plus saturating/wrapping up/down count with clear.
module encoder_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STEP       = 1,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned DIR_INVERT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             err_pulse
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic             w_cw_c;
    logic             w_ccw_c;
    logic             w_cw;
    logic             w_ccw;
    logic             w_err;
    logic             w_up_c;
    logic             w_down_c;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] r_count;

    quad_step_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_enc_a      (enc_a),
        .i_enc_b      (enc_b),
        .o_step_cw_c  (w_cw_c),
        .o_step_ccw_c (w_ccw_c),
        .o_step_cw    (w_cw),
        .o_step_ccw   (w_ccw),
        .o_err        (w_err)
    );

    // The counter consumes the same-cycle step so count and pulse land together.
    assign w_up_c   = (DIR_INVERT != 0) ? w_ccw_c : w_cw_c;
    assign w_down_c = (DIR_INVERT != 0) ? w_cw_c  : w_ccw_c;
    assign w_sum    = {1'b0, r_count} + STEP_X;
    assign w_diff   = {1'b0, r_count} - STEP_X;

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (w_up_c) begin
            if ((SATURATE != 0) && w_sum[WIDTH]) w_count_next = '1;
            else                                 w_count_next = w_sum[WIDTH-1:0];
        end else if (w_down_c) begin
            if ((SATURATE != 0) && w_diff[WIDTH]) w_count_next = '0;
            else                                  w_count_next = w_diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else       r_count <= w_count_next;
    end

    assign count      = r_count;
    assign up_pulse   = (DIR_INVERT != 0) ? w_ccw : w_cw;
    assign down_pulse = (DIR_INVERT != 0) ? w_cw  : w_ccw;
    assign err_pulse  = w_err;

endmodule
